// File: rtl/dma_ctrl_param.sv
// dma_ctrl_param: parametrised multi-channel 8237-style DMA controller with a 16-bit CPU register port.
// Latency: one arbitration cycle (REQ), then S1..S4 per transfer; register read data one cycle after i_reg_rd.
// Backpressure: bus ownership by o_hrq/i_hlda handshake; i_ready low holds S3 for wait states.
// Ports: i_clk, i_reset (sync, active-high); i_reg_cs/i_reg_wr/i_reg_rd/i_reg_addr/i_reg_wdata/o_reg_rdata;
//        i_dreq/o_dack device handshake; o_hrq/i_hlda bus hold; i_ready, i_eop_in; o_aen, o_addr,
//        o_memr/o_memw/o_ior/o_iow strobes, o_tc pulse, o_busy.
// Optional: define DMA_TC_IRQ_EN to add o_irq (OR of status TC flags, cleared by a status read).
module dma_ctrl_param #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_reg_cs,
    input  logic              i_reg_wr,
    input  logic              i_reg_rd,
    input  logic [5:0]        i_reg_addr,
    input  logic [15:0]       i_reg_wdata,
    output logic [15:0]       o_reg_rdata,
    input  logic [NUM_CH-1:0] i_dreq,
    output logic [NUM_CH-1:0] o_dack,
    output logic              o_hrq,
    input  logic              i_hlda,
    input  logic              i_ready,
    input  logic              i_eop_in,
    output logic              o_aen,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_memr,
    output logic              o_memw,
    output logic              o_ior,
    output logic              o_iow,
    output logic              o_tc,
    output logic              o_busy
`ifdef DMA_TC_IRQ_EN
    ,
    output logic              o_irq
`endif
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_S1, ST_S2, ST_S3, ST_S4} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base_addr [NUM_CH];
    logic [ADDR_W-1:0] r_cur_addr  [NUM_CH];
    logic [CNT_W-1:0]  r_base_cnt  [NUM_CH];
    logic [CNT_W-1:0]  r_cur_cnt   [NUM_CH];
    logic [5:0]        r_mode      [NUM_CH];
    logic [3:0]        r_cmd;
    logic [NUM_CH-1:0] r_mask, r_swreq, r_status, r_dack_act;
    logic [CH_W-1:0]   r_ch, r_last;
    logic              r_hrq, r_aen, r_memr, r_memw, r_ior, r_iow, r_tc;
    logic              r_eop, r_hlda_lost, r_stop;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_rdata;

    logic [NUM_CH-1:0] w_dreq_act, w_eff;
    logic [CH_W-1:0]   w_win;
    logic [15:0]       w_rd_dat;
    logic [5:0]        w_mode;
    logic [ADDR_W-1:0] w_nxt_addr;
    logic              w_reg_ok, w_rd, w_wr, w_clear, w_tc_now, w_eop_now, w_end;
    int                w_start, w_idx;

    assign w_dreq_act = i_dreq ^ {NUM_CH{r_cmd[2]}};
    assign w_eff      = ((w_dreq_act & ~r_mask) | r_swreq) & {NUM_CH{r_cmd[0]}};
    assign w_reg_ok   = (r_state == ST_IDLE) || (r_state == ST_REQ);
    assign w_rd       = i_reg_cs && i_reg_rd && w_reg_ok;
    assign w_wr       = i_reg_cs && i_reg_wr && w_reg_ok;
    assign w_clear    = i_reset || (w_wr && i_reg_addr == 6'h24);
    assign w_mode     = r_mode[r_ch];
    assign w_nxt_addr = w_mode[3] ? r_cur_addr[r_ch] - ADDR_W'(1) : r_cur_addr[r_ch] + ADDR_W'(1);
    assign w_tc_now   = (r_cur_cnt[r_ch] == '0);
    assign w_eop_now  = r_eop || i_eop_in;
    // Service ends after this S4 on TC/EOP, single mode, demand with the device idle, or lost hold.
    assign w_end      = r_stop || r_hlda_lost || !i_hlda || w_mode[4] ||
                        (w_mode[5:4] == 2'b00 && !w_dreq_act[r_ch]);

    // Search starts at channel 0 (fixed) or one past the last served channel (rotating).
    always_comb begin
        w_win   = '0;
        w_idx   = 0;
        w_start = r_cmd[1] ? (int'(r_last) + 1) % NUM_CH : 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_idx = (w_start + i) % NUM_CH;
            if (w_eff[w_idx[CH_W-1:0]]) w_win = w_idx[CH_W-1:0];
        end
    end

    always_comb begin
        w_rd_dat = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (i_reg_addr == 6'(c * 4))     w_rd_dat[ADDR_W-1:0] = r_cur_addr[c];
            if (i_reg_addr == 6'(c * 4 + 1)) w_rd_dat[CNT_W-1:0]  = r_cur_cnt[c];
            if (i_reg_addr == 6'(c * 4 + 2)) w_rd_dat[5:0]        = r_mode[c];
        end
        case (i_reg_addr)
            6'h20:   w_rd_dat[3:0]        = r_cmd;
            6'h21:   w_rd_dat[NUM_CH-1:0] = r_mask;
            6'h22:   w_rd_dat[NUM_CH-1:0] = r_swreq;
            6'h23:   w_rd_dat[NUM_CH-1:0] = r_status;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_clear) begin
            r_state     <= ST_IDLE;
            r_cmd       <= '0;
            r_mask      <= '1;
            r_swreq     <= '0;
            r_status    <= '0;
            r_dack_act  <= '0;
            r_ch        <= '0;
            r_last      <= CH_W'(NUM_CH - 1);
            r_hrq       <= 1'b0;
            r_aen       <= 1'b0;
            r_addr      <= '0;
            {r_memr, r_memw, r_ior, r_iow} <= '0;
            r_tc        <= 1'b0;
            r_eop       <= 1'b0;
            r_hlda_lost <= 1'b0;
            r_stop      <= 1'b0;
            r_rdata     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_base_addr[c] <= '0;
                r_cur_addr[c]  <= '0;
                r_base_cnt[c]  <= '0;
                r_cur_cnt[c]   <= '0;
                r_mode[c]      <= '0;
            end
        end else begin
            r_rdata <= '0;
            if (w_rd) begin
                r_rdata <= w_rd_dat;
                if (i_reg_addr == 6'h23) r_status <= '0;
            end
            if (w_wr) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (i_reg_addr == 6'(c * 4)) begin
                        r_base_addr[c] <= i_reg_wdata[ADDR_W-1:0];
                        r_cur_addr[c]  <= i_reg_wdata[ADDR_W-1:0];
                    end
                    if (i_reg_addr == 6'(c * 4 + 1)) begin
                        r_base_cnt[c] <= i_reg_wdata[CNT_W-1:0];
                        r_cur_cnt[c]  <= i_reg_wdata[CNT_W-1:0];
                    end
                    if (i_reg_addr == 6'(c * 4 + 2)) r_mode[c] <= i_reg_wdata[5:0];
                end
                case (i_reg_addr)
                    6'h20:   r_cmd   <= i_reg_wdata[3:0];
                    6'h21:   r_mask  <= i_reg_wdata[NUM_CH-1:0];
                    6'h22:   r_swreq <= i_reg_wdata[NUM_CH-1:0];
                    default: ;
                endcase
            end

            case (r_state)
                ST_IDLE: begin
                    if (|w_eff) begin
                        r_state <= ST_REQ;
                        r_hrq   <= 1'b1;
                        r_ch    <= w_win;
                    end
                end
                ST_REQ: begin
                    if (i_hlda) begin
                        r_state     <= ST_S1;
                        r_aen       <= 1'b1;
                        r_addr      <= r_cur_addr[r_ch];
                        r_dack_act  <= NUM_CH'(1) << r_ch;
                        r_eop       <= 1'b0;
                        r_hlda_lost <= 1'b0;
                        r_stop      <= 1'b0;
                    end else if (!w_eff[r_ch]) begin
                        r_state <= ST_IDLE;
                        r_hrq   <= 1'b0;
                    end
                end
                ST_S1: begin
                    r_state <= ST_S2;
                    if (!i_hlda) r_hlda_lost <= 1'b1;
                    r_ior  <= (w_mode[1:0] == 2'b01);
                    r_memw <= (w_mode[1:0] == 2'b01);
                    r_memr <= (w_mode[1:0] == 2'b10);
                    r_iow  <= (w_mode[1:0] == 2'b10);
                end
                ST_S2: begin
                    r_state <= ST_S3;
                    if (!i_hlda) r_hlda_lost <= 1'b1;
                    if (i_eop_in) r_eop <= 1'b1;
                end
                ST_S3: begin
                    if (!i_hlda) r_hlda_lost <= 1'b1;
                    if (i_eop_in) r_eop <= 1'b1;
                    if (i_ready) begin
                        r_state <= ST_S4;
                        {r_memr, r_memw, r_ior, r_iow} <= '0;
                        r_cur_addr[r_ch] <= w_nxt_addr;
                        r_cur_cnt[r_ch]  <= r_cur_cnt[r_ch] - CNT_W'(1);
                        r_stop           <= w_tc_now || w_eop_now;
                        if (w_tc_now) begin
                            r_tc           <= 1'b1;
                            r_status[r_ch] <= 1'b1;
                        end
                        // TC and EOP share the reload-or-mask action; only TC pulses and flags.
                        if (w_tc_now || w_eop_now) begin
                            if (w_mode[2]) begin
                                r_cur_addr[r_ch] <= r_base_addr[r_ch];
                                r_cur_cnt[r_ch]  <= r_base_cnt[r_ch];
                            end else begin
                                r_mask[r_ch] <= 1'b1;
                            end
                        end
                    end
                end
                ST_S4: begin
                    r_tc <= 1'b0;
                    if (w_end) begin
                        r_state       <= ST_IDLE;
                        r_hrq         <= 1'b0;
                        r_aen         <= 1'b0;
                        r_dack_act    <= '0;
                        r_swreq[r_ch] <= 1'b0;
                        r_last        <= r_ch;
                    end else begin
                        r_state <= ST_S1;
                        r_addr  <= r_cur_addr[r_ch];
                        r_eop   <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_reg_rdata = r_rdata;
    assign o_dack      = r_dack_act ^ {NUM_CH{r_cmd[3]}};
    assign o_hrq       = r_hrq;
    assign o_aen       = r_aen;
    assign o_addr      = r_addr;
    assign o_memr      = r_memr;
    assign o_memw      = r_memw;
    assign o_ior       = r_ior;
    assign o_iow       = r_iow;
    assign o_tc        = r_tc;
    assign o_busy      = (r_state != ST_IDLE);
`ifdef DMA_TC_IRQ_EN
    assign o_irq       = |r_status;
`endif
endmodule

// File: tb/tb_dma_ctrl_param.sv
// tb_dma_ctrl_param: directed bench for dma_ctrl_param (NUM_CH=4, ADDR_W=16, CNT_W=16).
// Latency: register vectors one access per few cycles; transfer scenarios bounded by cycle budgets.
// Backpressure: hlda follows hrq combinationally when enabled; ready/eop driven per scenario.
module tb_dma_ctrl_param;
    logic        clk = 1'b0;
    logic        reset, reg_cs, reg_wr, reg_rd, ready, eop_in, hlda_en;
    logic [5:0]  reg_addr;
    logic [15:0] reg_wdata, reg_rdata, addr;
    logic [3:0]  dreq, dack, strb;
    logic        hrq, hlda, aen, memr, memw, ior, iow, tc, busy;
`ifdef DMA_TC_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;
    assign hlda = hrq & hlda_en;
    assign strb = {memr, memw, ior, iow};

    dma_ctrl_param #(.NUM_CH(4), .ADDR_W(16), .CNT_W(16)) dut (
        .i_clk(clk), .i_reset(reset), .i_reg_cs(reg_cs), .i_reg_wr(reg_wr), .i_reg_rd(reg_rd),
        .i_reg_addr(reg_addr), .i_reg_wdata(reg_wdata), .o_reg_rdata(reg_rdata),
        .i_dreq(dreq), .o_dack(dack), .o_hrq(hrq), .i_hlda(hlda), .i_ready(ready),
        .i_eop_in(eop_in), .o_aen(aen), .o_addr(addr), .o_memr(memr), .o_memw(memw),
        .o_ior(ior), .o_iow(iow), .o_tc(tc), .o_busy(busy)
`ifdef DMA_TC_IRQ_EN
        , .o_irq(irq)
`endif
    );

    // Bus monitor: one record per strobe burst (S2..S3), plus tc pulse and hrq rise counts.
    logic [15:0] mon_addr[$];
    logic [3:0]  mon_strb[$];
    logic [3:0]  mon_dack[$];
    int          mon_len[$];
    int          cur_len = 0, tc_cnt = 0, hrq_rise = 0;
    logic [3:0]  prev_strb = '0;
    logic        prev_hrq = 1'b0;
    always @(negedge clk) begin
        if (strb != 0 && prev_strb == 0) begin
            mon_addr.push_back(addr);
            mon_strb.push_back(strb);
            mon_dack.push_back(dack);
            cur_len = 0;
        end
        if (strb != 0) cur_len++;
        if (strb == 0 && prev_strb != 0) mon_len.push_back(cur_len);
        if (tc) tc_cnt++;
        if (hrq && !prev_hrq) hrq_rise++;
        prev_strb = strb;
        prev_hrq  = hrq;
    end

    int total = 0, bad = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [5:0] a, input logic [15:0] d);
        reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        tick;
        reg_cs = 1'b0; reg_wr = 1'b0;
    endtask

    task automatic reg_read(input logic [5:0] a, output logic [15:0] d);
        reg_cs = 1'b1; reg_rd = 1'b1; reg_addr = a;
        tick;
        d = reg_rdata;
        reg_cs = 1'b0; reg_rd = 1'b0;
    endtask

    task automatic chk_reg(input string name, input logic [5:0] a, input logic [15:0] exp);
        logic [15:0] d;
        reg_read(a, d);
        check(name, d, exp);
    endtask

    task automatic chk_xfer(input int idx, input logic [15:0] ea, input logic [3:0] es, input logic [3:0] ed);
        check($sformatf("xfer%0d_present", idx), mon_addr.size() > idx, 1);
        if (mon_addr.size() > idx) begin
            check($sformatf("xfer%0d_addr", idx), mon_addr[idx], ea);
            check($sformatf("xfer%0d_strb", idx), mon_strb[idx], es);
            check($sformatf("xfer%0d_dack", idx), mon_dack[idx], ed);
        end
    endtask

    task automatic program_ch(input int ch, input logic [15:0] a, input logic [15:0] c, input logic [5:0] m);
        reg_write(6'(ch * 4), a);
        reg_write(6'(ch * 4 + 1), c);
        reg_write(6'(ch * 4 + 2), {10'd0, m});
    endtask

    typedef struct packed {
        logic        wr;
        logic [5:0]  a;
        logic [15:0] wd;
        logic [15:0] exp;
    } vec_t;
    vec_t vec [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, tb0, hb;
        logic stretched;

        vec[0]  = '{1'b0, 6'h21, 16'h0000, 16'h000F};
        vec[1]  = '{1'b0, 6'h20, 16'h0000, 16'h0000};
        vec[2]  = '{1'b0, 6'h00, 16'h0000, 16'h0000};
        vec[3]  = '{1'b1, 6'h00, 16'h1234, 16'h1234};
        vec[4]  = '{1'b1, 6'h05, 16'hBEEF, 16'hBEEF};
        vec[5]  = '{1'b1, 6'h0E, 16'hFFFF, 16'h003F};
        vec[6]  = '{1'b1, 6'h20, 16'hFFF0, 16'h0000};
        vec[7]  = '{1'b1, 6'h21, 16'hFFF5, 16'h0005};
        vec[8]  = '{1'b1, 6'h03, 16'hFFFF, 16'h0000};
        vec[9]  = '{1'b1, 6'h30, 16'hFFFF, 16'h0000};
        vec[10] = '{1'b0, 6'h23, 16'h0000, 16'h0000};
        vec[11] = '{1'b1, 6'h21, 16'h000F, 16'h000F};

        reset = 1'b1; reg_cs = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
        dreq = '0; ready = 1'b1; eop_in = 1'b0; hlda_en = 1'b1;
        tick; tick;
        reset = 1'b0;
        check("rst_hrq", hrq, 0);
        check("rst_aen", aen, 0);
        check("rst_busy", busy, 0);
        check("rst_dack", dack, 0);
        check("rst_strb", strb, 0);
        check("rst_tc", tc, 0);

        for (int i = 0; i < 12; i++) begin
            logic [15:0] d;
            if (vec[i].wr) reg_write(vec[i].a, vec[i].wd);
            reg_read(vec[i].a, d);
            check($sformatf("vec%0d_a%0h", i, vec[i].a), d, vec[i].exp);
        end

        // Master clear wipes channel registers written above.
        reg_write(6'h24, 16'h0000);
        chk_reg("mclr_addr0", 6'h00, 16'h0000);
        chk_reg("mclr_cnt1", 6'h05, 16'h0000);
        chk_reg("mclr_mode3", 6'h0E, 16'h0000);

        // Request withdrawn while waiting for hlda.
        hlda_en = 1'b0;
        reg_write(6'h20, 16'h0001);
        reg_write(6'h21, 16'h000E);
        dreq = 4'b0001;
        tick;
        check("req_hrq", hrq, 1);
        tick;
        check("req_hold_busy", busy, 1);
        dreq = 4'b0000;
        tick;
        check("drop_hrq", hrq, 0);
        check("drop_busy", busy, 0);
        hlda_en = 1'b1;
        reg_write(6'h21, 16'h000F);

        // Single-mode write on ch1, three services ending in TC.
        program_ch(1, 16'h1000, 16'd2, 6'h11);
        reg_write(6'h21, 16'h000D);
        b = mon_addr.size(); tb0 = tc_cnt; hb = hrq_rise;
        dreq = 4'b0010;
        repeat (40) tick;
        dreq = 4'b0000;
        check("t1_nxfer", mon_addr.size() - b, 3);
        for (int k = 0; k < 3; k++) chk_xfer(b + k, 16'h1000 + 16'(k), 4'b0110, 4'b0010);
        check("t1_tc", tc_cnt - tb0, 1);
        check("t1_hrq_rises", hrq_rise - hb, 3);
`ifdef DMA_TC_IRQ_EN
        check("t1_irq_set", irq, 1);
`endif
        chk_reg("t1_mask", 6'h21, 16'h000F);
        chk_reg("t1_status", 6'h23, 16'h0002);
        chk_reg("t1_status_clr", 6'h23, 16'h0000);
`ifdef DMA_TC_IRQ_EN
        check("t1_irq_clr", irq, 0);
`endif
        chk_reg("t1_curaddr", 6'h04, 16'h1003);

        // Block read on ch0, decrementing through zero, wait states in the second transfer.
        program_ch(0, 16'h0000, 16'd3, 6'h2A);
        b = mon_addr.size(); tb0 = tc_cnt; hb = hrq_rise;
        stretched = 1'b0;
        reg_write(6'h22, 16'h0001);
        for (int n = 0; n < 100; n++) begin
            tick;
            if (!stretched && mon_addr.size() == b + 2) begin
                stretched = 1'b1;
                ready = 1'b0;
                tick; tick;
                ready = 1'b1;
            end
        end
        check("t2_nxfer", mon_addr.size() - b, 4);
        chk_xfer(b + 0, 16'h0000, 4'b1001, 4'b0001);
        chk_xfer(b + 1, 16'hFFFF, 4'b1001, 4'b0001);
        chk_xfer(b + 2, 16'hFFFE, 4'b1001, 4'b0001);
        chk_xfer(b + 3, 16'hFFFD, 4'b1001, 4'b0001);
        if (mon_len.size() >= b + 4) begin
            check("t2_len0", mon_len[b], 2);
            check("t2_len1_wait", mon_len[b + 1], 4);
            check("t2_len2", mon_len[b + 2], 2);
        end
        check("t2_hrq_rises", hrq_rise - hb, 1);
        check("t2_tc", tc_cnt - tb0, 1);
        chk_reg("t2_status", 6'h23, 16'h0001);
        chk_reg("t2_swreq", 6'h22, 16'h0000);

        // Rotating priority between ch0 and ch2.
        reg_write(6'h24, 16'h0000);
        reg_write(6'h20, 16'h0003);
        program_ch(0, 16'h0100, 16'd5, 6'h11);
        program_ch(2, 16'h0200, 16'd5, 6'h11);
        reg_write(6'h21, 16'h000A);
        b = mon_addr.size();
        dreq = 4'b0101;
        for (int n = 0; n < 60 && mon_addr.size() < b + 3; n++) tick;
        dreq = 4'b0000;
        repeat (10) tick;
        check("t3_nxfer", mon_addr.size() - b, 3);
        chk_xfer(b + 0, 16'h0100, 4'b0110, 4'b0001);
        chk_xfer(b + 1, 16'h0200, 4'b0110, 4'b0100);
        chk_xfer(b + 2, 16'h0101, 4'b0110, 4'b0001);

        // Auto-init on ch3 with count 0, dack active-low.
        reg_write(6'h20, 16'h0009);
        check("t4_dack_idle", dack, 4'hF);
        program_ch(3, 16'h0040, 16'd0, 6'h15);
        reg_write(6'h21, 16'h0007);
        b = mon_addr.size(); tb0 = tc_cnt;
        dreq = 4'b1000;
        for (int n = 0; n < 30 && mon_addr.size() < b + 1; n++) tick;
        dreq = 4'b0000;
        repeat (10) tick;
        check("t4_nxfer", mon_addr.size() - b, 1);
        chk_xfer(b, 16'h0040, 4'b0110, 4'b0111);
        check("t4_tc", tc_cnt - tb0, 1);
        chk_reg("t4_addr_reload", 6'h0C, 16'h0040);
        chk_reg("t4_cnt_reload", 6'h0D, 16'h0000);
        chk_reg("t4_mask", 6'h21, 16'h0007);
        chk_reg("t4_status", 6'h23, 16'h0008);

        // External EOP during S3 of a block write.
        reg_write(6'h20, 16'h0001);
        program_ch(1, 16'h2000, 16'd5, 6'h21);
        reg_write(6'h21, 16'h000D);
        b = mon_addr.size(); tb0 = tc_cnt;
        reg_write(6'h22, 16'h0002);
        for (int n = 0; n < 30 && mon_addr.size() < b + 1; n++) tick;
        eop_in = 1'b1;
        tick;
        eop_in = 1'b0;
        repeat (20) tick;
        check("t5_nxfer", mon_addr.size() - b, 1);
        check("t5_tc", tc_cnt - tb0, 0);
        chk_reg("t5_status", 6'h23, 16'h0000);
        chk_reg("t5_mask", 6'h21, 16'h000F);
        chk_reg("t5_cnt", 6'h05, 16'h0004);
        chk_reg("t5_addr", 6'h04, 16'h2001);
        chk_reg("t5_swreq", 6'h22, 16'h0000);

        // Reset while strobes are up in S2.
        program_ch(0, 16'h0300, 16'd5, 6'h11);
        reg_write(6'h21, 16'h000E);
        dreq = 4'b0001;
        for (int n = 0; n < 30 && !memw; n++) tick;
        check("t6_reached_s2", memw, 1);
        reset = 1'b1;
        tick;
        check("t6_strb", strb, 0);
        check("t6_hrq", hrq, 0);
        check("t6_aen", aen, 0);
        check("t6_busy", busy, 0);
        check("t6_dack", dack, 0);
        reset = 1'b0;
        dreq = 4'b0000;
        chk_reg("t6_mask", 6'h21, 16'h000F);
        chk_reg("t6_addr", 6'h00, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dma_ctrl_param.md
Name: dma_ctrl_param

Overview:
- Parametrised multi-channel DMA controller, successor to the fixed 4-channel 8237-style block.
- Sits between the CPU register bus and the system bus arbiter.
- Per channel: base and current address/count; CPU programs it over a 16-bit register port.
- Requests bus via hrq/hlda, runs 4-state transfer cycles in demand, single or block mode, with fixed or rotating priority and auto-initialise.

Parameters:
- NUM_CH, 4, number of channels (1..8)
- ADDR_W, 16, transfer address width (1..16)
- CNT_W, 16, transfer count width (1..16)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- reg_cs  in  1  register-port select, active-high
- reg_wr  in  1  register write strobe, one cycle, qualified by reg_cs
- reg_rd  in  1  register read strobe, one cycle, qualified by reg_cs
- reg_addr  in  6  register index
- reg_wdata  in  16  write data
- reg_rdata  out  16  read data, valid the cycle after reg_rd
- dreq  in  NUM_CH  device requests, polarity per command[2]
- dack  out  NUM_CH  device acknowledges, polarity per command[3]
- hrq  out  1  bus hold request
- hlda  in  1  bus hold acknowledge
- ready  in  1  wait-state input, high = proceed
- eop_in  in  1  external end-of-process, active-high
- aen  out  1  DMA owns address bus
- addr  out  ADDR_W  transfer address
- memr, memw, ior, iow  out  1 each  bus strobes, active-high
- tc  out  1  terminal-count pulse
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (clk edge with reset=1):
  - state IDLE; all outputs 0, except dack = inactive level (all 0).
  - All registers cleared; mask = all ones.
- Register map (reg_addr):
  - ch*4+0: base/current address. Write loads both; read returns current.
  - ch*4+1: base/current count. Write loads both; read returns current.
  - ch*4+2: mode[5:0].
  - 0x20: command. [0] enable, [1] rotating priority, [2] dreq active-low, [3] dack active-low.
  - 0x21: mask[NUM_CH-1:0].
  - 0x22: software request bits.
  - 0x23: status. TC flag per channel; read clears it.
  - 0x24: write = master clear (same effect as reset).
  - Unused indices: read 0, writes ignored.
  - Upper unused data bits: read 0.
- Register accesses are honoured only in IDLE and REQ. Writes in S1–S4 are ignored; reads return 0.
- Mode register:
  - [1:0]: 01 write (ior+memw), 10 read (memr+iow), 00/11 verify (no strobes).
  - [2]: auto-init.
  - [3]: address decrement.
  - [5:4]: 00 demand, 01 single, 10 block, 11 treated as single.
- Effective request per channel:
  - ((dreq XOR command[2]) AND NOT mask) OR swreq, gated by command[0].
- States: IDLE, REQ, S1, S2, S3, S4.
- IDLE:
  - Any effective request → REQ, hrq=1.
  - Arbitrate once on entry to REQ. Fixed priority: channel 0 highest. Rotating: channel last served becomes lowest.
  - Winning channel is locked until end of service.
- REQ:
  - hrq held.
  - Locked request drops before hlda → IDLE, hrq=0.
  - hlda=1 → S1.
- S1: aen=1, addr=current address, dack[ch] active.
- S2: aen and dack held; mode strobes asserted.
- S3:
  - Strobes held.
  - Stay in S3 while ready=0.
  - ready=1 → S4.
- S4:
  - Strobes deassert.
  - Current address ±1, wrapping modulo 2^ADDR_W.
  - Current count −1.
  - TC when count was 0 before decrement (count+1 transfers total).
- End of service occurs on any of:
  - TC;
  - eop_in sampled high in S2 or S3;
  - single mode after one transfer;
  - demand mode with dreq inactive in S4;
  - hlda low in S4.
- Otherwise block/demand continue at S1 without releasing hrq.
- End of service:
  - hrq=0, aen=0, dack inactive, swreq bit for the channel cleared → IDLE.
- On TC:
  - tc=1 for the S4 cycle; status flag set.
  - If auto-init: current ← base, mask unchanged. Else mask bit set.
- On eop_in: same auto-init/mask action, no tc pulse, no status flag.
- Simultaneous TC and eop_in: TC behaviour.
- hlda falling in S1–S3 does not abort; the cycle completes, then service ends.
- reset or master clear mid-transfer: immediate return to reset values at that edge; strobes drop.

Optional Feature:
- Macro DMA_TC_IRQ_EN.
- Defined: adds output port irq (1 bit), irq = OR of status TC flags; clears when status is read.
- Undefined: no irq port; status is polled only.

Test Plan:
- Ch1 addr=0x1000, count=2, mode=0x11 (single, write), unmasked; dreq[1] held high → 3 separate services, addr 0x1000/0x1001/0x1002, ior+memw each, tc on third, mask[1] set, status=0x02.
- Ch0 block read, addr=0x0000, count=3, decrement, ready low 2 cycles in second transfer → addr 0x0000, 0xFFFF (wrap), 0xFFFE, 0xFFFD; memr+iow; second transfer S3 lasts 3 cycles; one hrq assertion throughout.
- dreq[0] and dreq[2] together, rotating priority → ch0 served first, then ch2; in the next simultaneous request ch2 wins only after ch0 rotates below it.
- Auto-init ch3, count=0, addr=0x0040 → one transfer, tc pulse, current addr/count reload to 0x0040/0, mask[3] stays 0.
- eop_in high in S3 of a block transfer with count=5 → service ends after that transfer, no tc, status unchanged, mask bit set.
- reset asserted in S2 → next edge: all strobes 0, hrq=0, state IDLE, mask=all ones.
